des_round_ctrl: RTL

//  Sequencer for the iterative single-round DES datapath: one shared round (E-expand, 48-bit
//  key XOR, S-boxes, P, 32-bit L XOR) reused 16 times. Issues load, per-round and final strobes,
//  and the C/D key-schedule rotation amount and direction for each round.

---
 rtl/des_round_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Sequencer for an iterative single-round DES datapath: issues load, per-round and final
// strobes plus the C/D key-schedule rotation for each of the sixteen rounds.
module des_round_ctrl #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             abort,
  input  logic             out_ready,
  output logic             ready,
  output logic             busy,
  output logic             load_in,
  output logic [CNT_W-1:0] round,
  output logic [1:0]       key_shift,
  output logic             key_dir,
  output logic             round_en,
  output logic             final_en,
  output logic             out_valid
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rnd_q, rnd_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;

  logic               ready_d, busy_d, load_in_d, key_dir_d;
  logic               round_en_d, final_en_d, out_valid_d;
  logic [CNT_W-1:0]   round_d;
  logic [1:0]         key_shift_d;

  // Decrypt round 1 consumes K16, which is the unrotated C/D straight out of PC1.
  function automatic logic [1:0] shift_of(input logic [CNT_W-1:0] r, input logic dec);
    if (dec && r == CNT_W'(1))
      return 2'd0;
    if (r == CNT_W'(1) || r == CNT_W'(2) || r == CNT_W'(9) || r == CNT_W'(16))
      return 2'd1;
    return 2'd2;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      load_in   <= 1'b0;
      round     <= '0;
      key_shift <= 2'd0;
      key_dir   <= 1'b0;
      round_en  <= 1'b0;
      final_en  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      ready     <= ready_d;
      busy      <= busy_d;
      load_in   <= load_in_d;
      round     <= round_d;
      key_shift <= key_shift_d;
      key_dir   <= key_dir_d;
      round_en  <= round_en_d;
      final_en  <= final_en_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          dir_d   = decrypt;
        end
      end
      LOAD: begin
        state_d = ROUND;
        rnd_d   = CNT_W'(1);
        cnt_d   = '0;
      end
      ROUND: begin
        if (cnt_q == SET_W'(SETTLE - 1)) begin
          cnt_d = '0;
          if (rnd_q == CNT_W'(ROUNDS)) begin
            state_d = FINAL;
            rnd_d   = '0;
          end else begin
            rnd_d = CNT_W'(rnd_q + 1'b1);
          end
        end else begin
          cnt_d = SET_W'(cnt_q + 1'b1);
        end
      end
      FINAL: state_d = HOLD;
      HOLD: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      rnd_d   = '0;
      cnt_d   = '0;
    end
  end

  // Output decode from the next state so every port comes straight from a flop.
  always_comb begin
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d == LOAD) || (state_d == ROUND) || (state_d == FINAL);
    load_in_d   = (state_d == LOAD);
    final_en_d  = (state_d == FINAL);
    out_valid_d = (state_d == HOLD);
    key_dir_d   = dir_d;
    round_d     = '0;
    key_shift_d = 2'd0;
    round_en_d  = 1'b0;
    if (state_d == ROUND) begin
      round_d     = rnd_d;
      key_shift_d = shift_of(rnd_d, dir_d);
      round_en_d  = (cnt_d == SET_W'(SETTLE - 1));
    end
  end

endmodule
